// File: rtl/morse_encoder.sv
// morse_encoder: packs five ASCII letters into an 80-bit Morse stream, one symbol or gap per clock.
// Optional MORSE_ENC_ERR_EN adds err and zeroes the frame when any letter is invalid.
module morse_encoder #(
    parameter int NUM_CHARS = 5,
    parameter int BITS_W = 80
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [7*NUM_CHARS-1:0] in_text,
    output logic [BITS_W-1:0]      out_bits,
    output logic                   valid,
    output logic                   busy
`ifdef MORSE_ENC_ERR_EN
    ,
    output logic                   err
`endif
);
    typedef enum logic [1:0] {IDLE, SYM, GAP, DONE} state_t;

    state_t state;
    logic [6:0] ptr;
    logic [2:0] letter;
    logic [2:0] len;
    logic [3:0] pat;
    logic [7*NUM_CHARS-1:0] sh;

    function automatic logic invalid(input logic [6:0] c);
        return c < 7'h41 || c > 7'h5a;
    endfunction

    // {symbol count, symbols MSB-first with 1 = dash}; anything outside A-Z falls back to 'E'
    function automatic logic [6:0] code_of(input logic [6:0] c);
        logic [4:0] i;
        logic [6:0] r;
        i = 5'(c - 7'h41);
        case (i)
            5'd0:  r = 7'b010_0100;
            5'd1:  r = 7'b100_1000;
            5'd2:  r = 7'b100_1010;
            5'd3:  r = 7'b011_1000;
            5'd5:  r = 7'b100_0010;
            5'd6:  r = 7'b011_1100;
            5'd7:  r = 7'b100_0000;
            5'd8:  r = 7'b010_0000;
            5'd9:  r = 7'b100_0111;
            5'd10: r = 7'b011_1010;
            5'd11: r = 7'b100_0100;
            5'd12: r = 7'b010_1100;
            5'd13: r = 7'b010_1000;
            5'd14: r = 7'b011_1110;
            5'd15: r = 7'b100_0110;
            5'd16: r = 7'b100_1101;
            5'd17: r = 7'b011_0100;
            5'd18: r = 7'b011_0000;
            5'd19: r = 7'b001_1000;
            5'd20: r = 7'b011_0010;
            5'd21: r = 7'b100_0001;
            5'd22: r = 7'b011_0110;
            5'd23: r = 7'b100_1001;
            5'd24: r = 7'b100_1011;
            5'd25: r = 7'b100_1100;
            default: r = 7'b001_0000;
        endcase
        return invalid(c) ? 7'b001_0000 : r;
    endfunction

`ifdef MORSE_ENC_ERR_EN
    logic [7*NUM_CHARS-1:0] text;
    logic bad;
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NUM_CHARS; i++) bad = bad | invalid(text[7*i +: 7]);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            out_bits <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            ptr      <= '0;
            letter   <= '0;
            len      <= '0;
            pat      <= '0;
            sh       <= '0;
`ifdef MORSE_ENC_ERR_EN
            text     <= '0;
            err      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    sh         <= {in_text[7*NUM_CHARS-8:0], 7'd0};
                    out_bits   <= '0;
                    ptr        <= 7'(BITS_W - 1);
                    letter     <= '0;
                    {len, pat} <= code_of(in_text[7*NUM_CHARS-1 -: 7]);
                    state      <= SYM;
                    valid      <= 1'b0;
                    busy       <= 1'b1;
`ifdef MORSE_ENC_ERR_EN
                    text       <= in_text;
                    err        <= 1'b0;
`endif
                end
                SYM: begin
                    if (pat[3]) begin
                        out_bits[ptr -: 4] <= 4'b1110;
                        ptr <= ptr - 7'd4;
                    end else begin
                        out_bits[ptr -: 2] <= 2'b10;
                        ptr <= ptr - 7'd2;
                    end
                    pat <= pat << 1;
                    len <= len - 3'd1;
                    if (len == 3'd1) state <= GAP;
                end
                GAP: begin
                    ptr <= ptr - 7'd2;
                    if (letter == 3'(NUM_CHARS - 1)) begin
                        state <= DONE;
                        valid <= 1'b1;
                        busy  <= 1'b0;
`ifdef MORSE_ENC_ERR_EN
                        err   <= bad;
                        if (bad) out_bits <= '0;
`endif
                    end else begin
                        letter     <= letter + 3'd1;
                        {len, pat} <= code_of(sh[7*NUM_CHARS-1 -: 7]);
                        sh         <= sh << 7;
                        state      <= SYM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: table-driven frames with hand-computed Morse images, plus busy-start and async-reset sequences.
module tb_morse_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [34:0] in_text = '0;
    logic [79:0] out_bits;
    logic valid, busy;
`ifdef MORSE_ENC_ERR_EN
    logic err;
`endif
    int compared = 0;
    int mismatched = 0;

    morse_encoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_text(in_text),
        .out_bits(out_bits), .valid(valid), .busy(busy)
`ifdef MORSE_ENC_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [34:0] text;
        logic [79:0] bits;
        int          lat;
        logic        bad;
        int          poke;
    } vec_t;

    vec_t vec [9];

    function automatic logic [34:0] txt(input string s);
        logic [34:0] r;
        byte b;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            b = s[i];
            r = {r[27:0], b[6:0]};
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_frame(input string nm, input vec_t v);
        int n;
        logic bz;
        logic [79:0] exp;
        exp = v.bits;
`ifdef MORSE_ENC_ERR_EN
        if (v.bad) exp = '0;
`endif
        @(negedge clk);
        start = 1'b1;
        in_text = v.text;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_text = 35'h7ffffffff;
        chk({nm, " valid_low"}, 80'(valid), 80'd0);
        n = 0;
        bz = 1'b1;
        while (!valid && n < 40) begin
            if (busy !== 1'b1) bz = 1'b0;
            if (n == v.poke) begin
                start = 1'b1;
                in_text = txt("TTTTT");
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        chk({nm, " latency"}, 80'(n), 80'(v.lat));
        chk({nm, " busy_during"}, 80'(bz), 80'd1);
        chk({nm, " busy_done"}, 80'(busy), 80'd0);
        chk({nm, " bits"}, out_bits, exp);
`ifdef MORSE_ENC_ERR_EN
        chk({nm, " err"}, 80'(err), 80'(v.bad));
`endif
        repeat (3) @(posedge clk);
        #1;
        chk({nm, " hold"}, {out_bits[78:0], valid}, {exp[78:0], 1'b1});
    endtask

    initial begin
        vec[0] = '{txt("EEEEE"), 80'h88888000000000000000, 10, 1'b0, -1};
        vec[1] = '{txt("TTTTT"), 80'hE38E38E0000000000000, 10, 1'b0, -1};
        vec[2] = '{txt("JJJJJ"), 80'hBBB8BBB8BBB8BBB8BBB8, 25, 1'b0, -1};
        vec[3] = '{txt("EEEEE"), 80'h88888000000000000000, 10, 1'b0, 3};
        vec[4] = '{txt("TTTTT"), 80'hE38E38E0000000000000, 10, 1'b0, -1};
        vec[5] = '{txt("SOSAT"), 80'hA8EEE2A2E38000000000, 17, 1'b0, -1};
        vec[6] = '{txt("VWXYZ"), 80'hAB8BB8EAE3AEE3BA8000, 24, 1'b0, -1};
        vec[7] = '{txt("E@EEE"), 80'h88888000000000000000, 10, 1'b1, -1};
        vec[8] = '{txt("EEEE["), 80'h88888000000000000000, 10, 1'b1, -1};
        #12;
        chk("reset bits", out_bits, 80'd0);
        chk("reset flags", {78'd0, valid, busy}, 80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) run_frame($sformatf("vec%0d", i), vec[i]);
        @(negedge clk);
        start = 1'b1;
        in_text = txt("JJJJJ");
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset bits", out_bits, 80'd0);
        chk("async_reset flags", {78'd0, valid, busy}, 80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("after_reset", vec[5]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
